// File: rtl/mc_sequencer_pkg.sv
// Shared types for the multi-cycle control sequencer: state encoding, instruction
// field constants, datapath select codes and the instruction classifier.
package mc_pkg;

    typedef enum logic [3:0] {
        StIf,
        StId,
        StEx,
        StWb,
        StMaddr,
        StMrd,
        StMwb,
        StMwr,
        StBr,
        StLink,
        StJump,
        StJreg,
        StWwd,
        StHalt
    } state_e;

    localparam logic [3:0] OpBne   = 4'd0;
    localparam logic [3:0] OpBeq   = 4'd1;
    localparam logic [3:0] OpBgz   = 4'd2;
    localparam logic [3:0] OpBlz   = 4'd3;
    localparam logic [3:0] OpAdi   = 4'd4;
    localparam logic [3:0] OpOri   = 4'd5;
    localparam logic [3:0] OpLhi   = 4'd6;
    localparam logic [3:0] OpLwd   = 4'd7;
    localparam logic [3:0] OpSwd   = 4'd8;
    localparam logic [3:0] OpJmp   = 4'd9;
    localparam logic [3:0] OpJal   = 4'd10;
    localparam logic [3:0] OpRtype = 4'd15;

    // R-type funcs 0..7 map one-to-one onto the ALU operation codes.
    localparam logic [5:0] FnAluLast = 6'd7;
    localparam logic [5:0] FnJpr     = 6'd25;
    localparam logic [5:0] FnJrl     = 6'd26;
    localparam logic [5:0] FnWwd     = 6'd28;
    localparam logic [5:0] FnHlt     = 6'd29;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluNot  = 4'd4,
        AluTcp  = 4'd5,
        AluShl  = 4'd6,
        AluShr  = 4'd7,
        AluLhi  = 4'd8,
        AluJtgt = 4'd9,
        AluBne  = 4'd10,
        AluBeq  = 4'd11,
        AluBgz  = 4'd12,
        AluBlz  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcBRt   = 2'd0,
        SrcBOne  = 2'd1,
        SrcBImm  = 2'd2,
        SrcBZero = 2'd3
    } src_b_e;

    typedef enum logic [1:0] {
        ImmZext   = 2'd0,
        ImmSext   = 2'd1,
        ImmTarget = 2'd2
    } imm_sel_e;

    typedef enum logic [1:0] {
        DstRs = 2'd0,
        DstRt = 2'd1,
        DstRd = 2'd2,
        DstR2 = 2'd3
    } reg_dst_e;

    typedef enum logic [3:0] {
        ClsNop,
        ClsBranch,
        ClsAluR,
        ClsAluI,
        ClsLoad,
        ClsStore,
        ClsJmp,
        ClsJal,
        ClsJpr,
        ClsJrl,
        ClsWwd,
        ClsHlt
    } inst_class_e;

    typedef struct packed {
        logic     pc_write;
        logic     pc_write_cond;
        logic     pc_source;
        logic     i_or_d;
        logic     mem_read;
        logic     mem_write;
        logic     data_drive;
        logic     ir_write;
        logic     mdr_write;
        logic     alu_reg_write;
        logic     reg_write;
        logic     mem_to_reg;
        logic     alu_src_a;
        src_b_e   alu_src_b;
        imm_sel_e imm_sel;
        reg_dst_e reg_dst;
        alu_op_e  alu_op;
        logic     inst_done;
        logic     wwd_strobe;
        logic     halted;
    } ctrl_t;

    function automatic inst_class_e classify(input logic [3:0] opcode, input logic [5:0] func);
        inst_class_e cls;
        cls = ClsNop;
        case (opcode)
            OpBne, OpBeq, OpBgz, OpBlz: cls = ClsBranch;
            OpAdi, OpOri, OpLhi:        cls = ClsAluI;
            OpLwd:                      cls = ClsLoad;
            OpSwd:                      cls = ClsStore;
            OpJmp:                      cls = ClsJmp;
            OpJal:                      cls = ClsJal;
            OpRtype: begin
                if (func <= FnAluLast) begin
                    cls = ClsAluR;
                end else begin
                    case (func)
                        FnJpr:   cls = ClsJpr;
                        FnJrl:   cls = ClsJrl;
                        FnWwd:   cls = ClsWwd;
                        FnHlt:   cls = ClsHlt;
                        default: cls = ClsNop;
                    endcase
                end
            end
            default: cls = ClsNop;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Instruction fields, memory handshake and datapath control vector between the
// sequencer (master) and the datapath (slave).
interface mc_sequencer_if;

    logic [3:0] opcode;
    logic [5:0] func;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       data_drive;
    logic       ir_write;
    logic       mdr_write;
    logic       alu_reg_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_sel;
    logic [1:0] reg_dst;
    logic [3:0] alu_op;
    logic       inst_done;
    logic       wwd_strobe;
    logic       halted;

    modport master (
        input  opcode, func, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, data_drive,
               ir_write, mdr_write, alu_reg_write, reg_write, mem_to_reg, alu_src_a,
               alu_src_b, imm_sel, reg_dst, alu_op, inst_done, wwd_strobe, halted
    );

    modport slave (
        output opcode, func, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, data_drive,
               ir_write, mdr_write, alu_reg_write, reg_write, mem_to_reg, alu_src_a,
               alu_src_b, imm_sel, reg_dst, alu_op, inst_done, wwd_strobe, halted
    );

endinterface

// File: rtl/mc_out_decode.sv
// Combinational control-vector decoder: maps the current sequencer state plus the
// latched instruction fields and memory handshake onto every datapath enable/select.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    inst_class_e cls;
    alu_op_e     ex_alu_op;
    alu_op_e     br_alu_op;

    assign cls = classify(opcode, func);

    always_comb begin
        ex_alu_op = AluAdd;
        if (cls == ClsAluR) begin
            ex_alu_op = alu_op_e'({1'b0, func[2:0]});
        end else begin
            case (opcode)
                OpOri:   ex_alu_op = AluOr;
                OpLhi:   ex_alu_op = AluLhi;
                default: ex_alu_op = AluAdd;
            endcase
        end
    end

    always_comb begin
        case (opcode)
            OpBne:   br_alu_op = AluBne;
            OpBeq:   br_alu_op = AluBeq;
            OpBgz:   br_alu_op = AluBgz;
            default: br_alu_op = AluBlz;
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (state)
            StIf: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SrcBOne;
                end
            end
            StId: begin
                // Branch target is computed speculatively for every instruction.
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SrcBImm;
                ctrl.imm_sel       = ImmSext;
                ctrl.alu_reg_write = 1'b1;
                ctrl.inst_done     = (cls == ClsNop);
            end
            StEx: begin
                ctrl.alu_src_b     = (cls == ClsAluR) ? SrcBRt : SrcBImm;
                ctrl.imm_sel       = (opcode == OpAdi) ? ImmSext : ImmZext;
                ctrl.alu_op        = ex_alu_op;
                ctrl.alu_reg_write = 1'b1;
            end
            StWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = (cls == ClsAluR) ? DstRd : DstRt;
                ctrl.inst_done = 1'b1;
            end
            StMaddr: begin
                ctrl.alu_src_b     = SrcBImm;
                ctrl.imm_sel       = ImmSext;
                ctrl.alu_reg_write = 1'b1;
            end
            StMrd: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.mdr_write = mem_ready;
            end
            StMwb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = DstRt;
                ctrl.inst_done  = 1'b1;
            end
            StMwr: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.data_drive = 1'b1;
                ctrl.inst_done  = mem_ready;
            end
            StBr: begin
                ctrl.alu_op        = br_alu_op;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                ctrl.inst_done     = 1'b1;
            end
            StLink: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SrcBZero;
                ctrl.alu_reg_write = 1'b1;
            end
            StJump: begin
                ctrl.alu_op    = AluJtgt;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.imm_sel   = ImmTarget;
                ctrl.pc_write  = 1'b1;
                if (cls == ClsJal) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = DstR2;
                end
                ctrl.inst_done = 1'b1;
            end
            StJreg: begin
                ctrl.alu_src_b = SrcBZero;
                ctrl.pc_write  = 1'b1;
                // Return address was parked in ALUReg by LINK.
                if (cls == ClsJrl) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = DstR2;
                end
                ctrl.inst_done = 1'b1;
            end
            StWwd: begin
                ctrl.wwd_strobe = 1'b1;
                ctrl.inst_done  = 1'b1;
            end
            StHalt: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: state register and next-state logic; the control
// vector itself comes from mc_out_decode and is forced low while reset is held.
module mc_sequencer
    import mc_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    mc_sequencer_if.master bus
);

    state_e      state_q;
    state_e      state_d;
    inst_class_e cls;
    ctrl_t       ctrl;
    ctrl_t       ctrl_out;

    assign cls = classify(bus.opcode, bus.func);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf: state_d = bus.mem_ready ? StId : StIf;
            StId: begin
                case (cls)
                    ClsBranch:         state_d = StBr;
                    ClsAluR, ClsAluI:  state_d = StEx;
                    ClsLoad, ClsStore: state_d = StMaddr;
                    ClsJmp:            state_d = StJump;
                    ClsJal, ClsJrl:    state_d = StLink;
                    ClsJpr:            state_d = StJreg;
                    ClsWwd:            state_d = StWwd;
                    ClsHlt:            state_d = StHalt;
                    default:           state_d = StIf;
                endcase
            end
            StEx:    state_d = StWb;
            StMaddr: state_d = (cls == ClsLoad) ? StMrd : StMwr;
            StMrd:   state_d = bus.mem_ready ? StMwb : StMrd;
            StMwr:   state_d = bus.mem_ready ? StIf : StMwr;
            StLink:  state_d = (cls == ClsJal) ? StJump : StJreg;
            StHalt:  state_d = StHalt;
            StWb, StMwb, StBr, StJump, StJreg, StWwd: state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    mc_out_decode u_decode (
        .state    (state_q),
        .opcode   (bus.opcode),
        .func     (bus.func),
        .mem_ready(bus.mem_ready),
        .ctrl     (ctrl)
    );

    // Bus strobes must drop as soon as reset asserts, without waiting for a clock.
    assign ctrl_out = reset_n ? ctrl : ctrl_t'('0);

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.data_drive    = ctrl_out.data_drive;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mdr_write     = ctrl_out.mdr_write;
    assign bus.alu_reg_write = ctrl_out.alu_reg_write;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.imm_sel       = ctrl_out.imm_sel;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.inst_done     = ctrl_out.inst_done;
    assign bus.wwd_strobe    = ctrl_out.wwd_strobe;
    assign bus.halted        = ctrl_out.halted;

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the 16-bit single-memory-port CPU datapath. It walks each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It waits on a memory ready handshake, so memory may insert wait states. It sits between the instruction register (opcode/func inputs) and the datapath: PC, IR, MDR, ALUReg, register file, ALU and the memory bus.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  4  IR[15:12], valid from the cycle after ir_write
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write, pc_write_cond  out  1  PC enable; conditional enable gated by ALU bcond in datapath
- pc_source  out  1  0 = ALU result, 1 = ALUReg
- i_or_d  out  1  0 = PC address, 1 = ALUReg address
- mem_read, mem_write, data_drive  out  1  memory bus controls; data_drive enables rt onto bus
- ir_write, mdr_write, alu_reg_write, reg_write  out  1  register enables, sampled on clk rise
- mem_to_reg  out  1  0 = ALUReg, 1 = MDR
- alu_src_a  out  1  0 = rs data, 1 = PC
- alu_src_b  out  2  0 = rt data, 1 = +1, 2 = immediate, 3 = 0
- imm_sel  out  2  0 = zero-ext imm8, 1 = sign-ext imm8, 2 = target12
- reg_dst  out  2  0 = rs, 1 = rt, 2 = rd, 3 = r2
- alu_op  out  4  ALU operation code
- inst_done  out  1  one-cycle pulse on last cycle of each instruction
- wwd_strobe  out  1  one-cycle output-port capture of rs
- halted  out  1  high in HALT state

## Operation
- States: IF, ID, EX, WB, MADDR, MRD, MWB, MWR, BR, LINK, JUMP, JREG, WWD, HALT.
- IF:
  - i_or_d=0, mem_read=1.
  - Hold until mem_ready.
  - In the ready cycle: ir_write=1, pc_write=1, ALU=PC+1 (src_a=1, src_b=1, ADD, pc_source=0); go to ID.
- ID: ALUReg <= PC + sext(imm8) (branch target). Dispatch:
  - branches BNE/BEQ/BGZ/BLZ (0-3) -> BR
  - ADI/ORI/LHI (4-6) and R-type ALU funcs 0-7 -> EX
  - LWD/SWD (7/8) -> MADDR
  - JMP (9) -> JUMP
  - JAL (10), JRL (func 26) -> LINK
  - JPR (func 25) -> JREG
  - WWD (func 28) -> WWD
  - HLT (func 29) -> HALT
  - any other opcode/func -> IF with inst_done (NOP)
- EX: src_a=0; src_b=0 (R) or 2 (I); imm_sel=1 for ADI, 0 for ORI/LHI; alu_op per instruction; alu_reg_write=1; go to WB.
- WB: reg_write=1, mem_to_reg=0, reg_dst=2 (R) or 1 (I); inst_done; go to IF.
- MADDR: ALUReg <= rs + sext(imm8); go to MRD (LWD) or MWR (SWD).
- MRD: i_or_d=1, mem_read=1 until mem_ready; mdr_write in the ready cycle; go to MWB.
- MWB: reg_write, mem_to_reg=1, reg_dst=1; inst_done; go to IF.
- MWR: i_or_d=1, mem_write=1, data_drive=1 until mem_ready; inst_done in the ready cycle; go to IF.
- BR: src_a=0, src_b=0, alu_op=branch compare, pc_write_cond=1, pc_source=1; inst_done; go to IF.
- LINK: ALUReg <= PC+0 (src_a=1, src_b=3); go to JUMP (JAL) or JREG (JRL).
- JUMP: alu_op=JTGT ({A[15:12], B[11:0]}), src_a=1, src_b=2, imm_sel=2, pc_write; if JAL also reg_write, reg_dst=3, mem_to_reg=0; inst_done; go to IF.
- JREG: ALU=rs+0, pc_write; if JRL also reg_write to r2 from ALUReg; inst_done; go to IF.
- WWD: wwd_strobe; inst_done; go to IF.
- HALT: halted=1, all other outputs 0; state held until reset.

## Timing
- Reset (asynchronous): state=IF; all outputs 0 except the IF combinational levels (mem_read=1, i_or_d=0) once reset_n deasserts.
- Reset mid-access drops mem_write/data_drive in the same cycle.
- Outputs are combinational from state, opcode, func and mem_ready. Enables are levels sampled on the clk rise.
- Cycle counts with zero wait states:
  - R/I ALU 4; LWD 5; SWD 4; branch 3; JMP 3; JAL/JRL 4; JPR 3; WWD 3; HLT enters HALT at cycle 3.
  - Each memory wait cycle adds 1.
- mem_ready outside IF/MRD/MWR is ignored.
- mem_ready stuck low holds the state indefinitely.
- inst_done is never asserted in HALT.

## Structure
- Package mc_pkg holds:
  - state enum
  - opcode and func constants
  - alu_op codes: ADD=0, SUB=1, AND=2, OR=3, NOT=4, TCP=5, SHL=6, SHR=7, LHI=8, JTGT=9, BNE=10, BEQ=11, BGZ=12, BLZ=13
  - alu_src_b, imm_sel and reg_dst select codes
- One sub-module, mc_out_decode: combinational state/opcode/func to control-vector decoder. The sequencer itself keeps only the state register and the next-state logic.

## Test plan
- ADD (opcode 15, func 0), mem_ready tied 1:
  - IF,ID,EX,WB in 4 cycles
  - alu_op=0 and reg_dst=2 in WB
  - one inst_done pulse
- LWD with mem_ready low for 2 cycles in MRD:
  - 7 total cycles
  - mdr_write only in the ready cycle
  - mem_to_reg=1 in MWB
- BEQ:
  - BR asserts pc_write_cond=1, pc_source=1, alu_op=11
  - returns to IF after 3 cycles
- JAL:
  - LINK then JUMP
  - reg_dst=3 with reg_write, pc_write, imm_sel=2, alu_op=9 in the same cycle
- HLT (func 29):
  - halted rises in cycle 3 and stays high for 20 cycles with mem_ready toggling
  - inst_done stays 0
- reset_n pulled low during MWR:
  - mem_write and data_drive drop with no clock edge
  - after release, state is IF with mem_read=1
